vliw_bundle_issue: RTL and testbench

Issue stage directly upstream of the 4-slot VLIW processor. Accepts 128-bit instruction bundles from the scheduler over a valid/ready handshake and buffers them in a FIFO. Each cycle it drives exactly one registered bundle onto the processor's `vliw_instr` input, inserting all-zero NOP bundles when the FIFO is empty or issue is stalled. Provides flush, occupancy status and issue statistics.

---
 rtl/vliw_bundle_issue.sv | 129 ++++++++++++
 tb/tb_vliw_bundle_issue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vliw_bundle_issue.sv
// vliw_bundle_issue: bundle FIFO plus registered issue slot feeding a 4-slot VLIW core.
// A NOP (all zeros) is driven on every cycle that does not pop the FIFO.
// Optional build macro VLIW_WAW_SQUASH_EN: clears the valid bit of any slot whose
// dest is also written by a higher-numbered valid slot in the same bundle, and
// counts the squashed slots in waw_count. When undefined, bundles pass through
// untouched and waw_count is tied to 0.
module vliw_bundle_issue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [127:0]             in_bundle,
  output logic                     in_ready,
  input  logic                     issue_en,
  input  logic                     flush,
  output logic [127:0]             vliw_instr,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     empty,
  output logic                     full,
  output logic [CNT_W-1:0]         issued_count,
  output logic [CNT_W-1:0]         nop_count,
  output logic [CNT_W-1:0]         waw_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic          push, pop;
  logic [127:0]  head, iss;

  // Status comes from the registered level only; no ready-from-pop bypass.
  assign fifo_level = level;
  assign empty      = (level == '0);
  assign full       = (level == LW'(DEPTH));
  assign in_ready   = !full;

  // Flush overrides both sides of the handshake.
  assign push = in_valid && in_ready && !flush;
  assign pop  = issue_en && !empty && !flush;
  assign head = mem[rptr];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

`ifdef VLIW_WAW_SQUASH_EN
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 32;

  logic [NUM_LANES-1:0][VEC_W-1:0] head_v, iss_v;
  logic [NUM_LANES-1:0]            sq;
  logic [2:0]                      sq_n;

  assign head_v = head;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic             kill;
    logic [VEC_W-1:0] slot;
    // A slot dies when any later valid slot targets the same dest (last writer wins).
    always_comb begin
      kill = 1'b0;
      for (int j = i + 1; j < NUM_LANES; j++)
        if (head_v[i][VEC_W-1] && head_v[j][VEC_W-1] && (head_v[i][5:3] == head_v[j][5:3]))
          kill = 1'b1;
      slot          = head_v[i];
      slot[VEC_W-1] = head_v[i][VEC_W-1] & ~kill;
    end
    assign sq[i]    = kill;
    assign iss_v[i] = slot;
  end

  assign iss  = iss_v;
  assign sq_n = 3'($countones(sq));

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Accumulate squashed slots for each issued bundle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    waw_count <= '0;
    else if (pop) waw_count <= sat_add(waw_count, sq_n);
  end
`else
  assign iss       = head;
  assign waw_count = '0;
`endif

  // Bundle storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_bundle;
  end

  // Pointers, occupancy, issue register and issue/NOP statistics.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      vliw_instr   <= '0;
      issued_count <= '0;
      nop_count    <= '0;
    end else begin
      if (pop) issued_count <= sat_inc(issued_count);
      else     nop_count    <= sat_inc(nop_count);
      if (flush) begin
        wptr       <= '0;
        rptr       <= '0;
        level      <= '0;
        vliw_instr <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        vliw_instr <= pop ? iss : '0;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vliw_bundle_issue.sv
// Self-checking bench for vliw_bundle_issue: table vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_vliw_bundle_issue;
  localparam int DEPTH = 8;
  localparam int unsigned CMAX = 65535;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         in_valid = 1'b0, issue_en = 1'b0, flush = 1'b0;
  logic [127:0] in_bundle = '0;
  logic         in_ready, empty, full;
  logic [127:0] vliw_instr;
  logic [3:0]   fifo_level;
  logic [15:0]  issued_count, nop_count, waw_count;

  // Small instance for counter saturation, left idle.
  logic         in_ready2, empty2, full2;
  logic [127:0] vliw2;
  logic [1:0]   level2;
  logic [3:0]   iss2, nop2, waw2;

  vliw_bundle_issue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_bundle(in_bundle),
    .in_ready(in_ready), .issue_en(issue_en), .flush(flush),
    .vliw_instr(vliw_instr), .fifo_level(fifo_level), .empty(empty), .full(full),
    .issued_count(issued_count), .nop_count(nop_count), .waw_count(waw_count));

  vliw_bundle_issue #(.DEPTH(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rstn(rstn), .in_valid(1'b0), .in_bundle(128'h0),
    .in_ready(in_ready2), .issue_en(1'b0), .flush(1'b0),
    .vliw_instr(vliw2), .fifo_level(level2), .empty(empty2), .full(full2),
    .issued_count(iss2), .nop_count(nop2), .waw_count(waw2));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model state
  logic [127:0] q[$];
  logic [127:0] m_v;
  int unsigned  m_iss, m_nop, m_waw;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Last-writer-wins rule applied slot by slot.
  function automatic logic [127:0] squash(input logic [127:0] b, output int n);
    logic [127:0] r;
    r = b;
    n = 0;
`ifdef VLIW_WAW_SQUASH_EN
    for (int i = 0; i < 4; i++) begin
      bit later_writer;
      later_writer = 0;
      for (int j = i + 1; j < 4; j++)
        if (b[32*i+31] && b[32*j+31] && b[32*i+3 +: 3] == b[32*j+3 +: 3]) later_writer = 1;
      if (later_writer) begin
        r[32*i+31] = 1'b0;
        n++;
      end
    end
`endif
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_v = '0;
    m_iss = 0;
    m_nop = 0;
    m_waw = 0;
  endtask

  task automatic model_edge();
    bit do_push, do_pop;
    int n;
    do_push = in_valid && (q.size() < DEPTH) && !flush;
    do_pop  = issue_en && (q.size() != 0) && !flush;
    if (do_pop) begin
      m_v = squash(q.pop_front(), n);
      if (m_iss < CMAX) m_iss++;
      m_waw = (m_waw + n > CMAX) ? CMAX : m_waw + n;
    end else begin
      m_v = '0;
      if (m_nop < CMAX) m_nop++;
    end
    if (flush) q.delete();
    else if (do_push) q.push_back(in_bundle);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("vliw", vliw_instr, m_v);
    chk("level", fifo_level, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("issued", issued_count, m_iss);
    chk("nop", nop_count, m_nop);
    chk("waw", waw_count, m_waw);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_vliw", vliw_instr, 128'h0);
    chk("rst_level", fifo_level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_issued", issued_count, 0);
    chk("rst_nop", nop_count, 0);
    chk("rst_waw", waw_count, 0);
    chk("rst_nop_small", nop2, 0);
    model_reset();
    #1;
    rstn = 1'b1;
  endtask

  typedef struct {
    logic         v;
    logic [127:0] b;
    logic         ie;
    logic [127:0] ev;
    logic [3:0]   el;
  } vec_t;

  localparam logic [127:0] A = 128'h8000_0008_8000_0010_8000_0018_8000_0020;
  localparam logic [127:0] B = 128'h0000_0000_0000_0000_0000_0000_0000_1234;
  localparam logic [127:0] W = 128'h8000_0028_8000_0028_8000_0008_8000_0028;
`ifdef VLIW_WAW_SQUASH_EN
  localparam logic [127:0] W_ISS = 128'h8000_0028_0000_0028_8000_0008_0000_0028;
  localparam int           W_CNT = 2;
`else
  localparam logic [127:0] W_ISS = W;
  localparam int           W_CNT = 0;
`endif

  initial begin
    vec_t tbl[6];
    logic [127:0] pushed[20];

    tbl[0] = '{1'b1, A,    1'b0, 128'h0, 4'd1};
    tbl[1] = '{1'b1, B,    1'b1, A,      4'd1};
    tbl[2] = '{1'b0, '0,   1'b1, B,      4'd0};
    tbl[3] = '{1'b1, W,    1'b0, 128'h0, 4'd1};
    tbl[4] = '{1'b0, '0,   1'b1, W_ISS,  4'd0};
    tbl[5] = '{1'b0, '0,   1'b1, 128'h0, 4'd0};

    // Reset, then counter saturation on the narrow instance.
    do_reset();
    for (int c = 0; c < 20; c++) step();
    chk("nop_sat", nop2, 4'hF);

    // Table vectors: latency, all-invalid bundle, WAW squash.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      in_valid = tbl[k].v;
      in_bundle = tbl[k].b;
      issue_en = tbl[k].ie;
      step();
      chk($sformatf("tbl%0d_vliw", k), vliw_instr, tbl[k].ev);
      chk($sformatf("tbl%0d_level", k), fifo_level, tbl[k].el);
    end
    chk("tbl_waw", waw_count, W_CNT);
    chk("tbl_issued", issued_count, 3);
    chk("tbl_nop", nop_count, 3);

    // Fill with stall, ninth push refused, then drain in order.
    do_reset();
    issue_en = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      in_bundle = 128'(32'h8000_0000 | k);
      step();
      if (k == 7) begin
        chk("fill_ready", in_ready, 0);
        chk("fill_full", full, 1);
      end
    end
    chk("fill_level", fifo_level, 8);
    in_valid = 1'b0;
    issue_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("drain%0d", k), vliw_instr, 128'(32'h8000_0000 | k));
    end
    step();
    chk("drain_nop", vliw_instr, 128'h0);
    chk("drain_issued", issued_count, 8);

    // Streaming push+issue every cycle.
    do_reset();
    issue_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      int n;
      in_valid = 1'b1;
      in_bundle = {$urandom, $urandom, $urandom, $urandom};
      pushed[c] = in_bundle;
      step();
      chk("stream_lvl", fifo_level <= 1, 1);
      if (c >= 1) chk($sformatf("stream%0d", c), vliw_instr, squash(pushed[c-1], n));
    end
    chk("stream_nop", nop_count, 1);
    in_valid = 1'b0;
    step();
    step();

    // Flush with five buffered entries and a concurrent push.
    do_reset();
    issue_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_bundle = {96'h0, 32'h8000_0100 + 32'(k)};
      step();
    end
    in_bundle = 128'h8000_0018_8000_0010_8000_0008_8000_0000;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_vliw", vliw_instr, 128'h0);
    chk("flush_level", fifo_level, 0);
    issue_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_never_issued", vliw_instr, 128'h0);
    end
    chk("flush_issued", issued_count, 0);

    // Reset mid-stream with three buffered entries.
    issue_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_bundle = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", fifo_level, 3);
    do_reset();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      issue_en = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      in_bundle = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    issue_en = 1'b0;
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
